// File: rtl/trap_ctrl_if.sv
// Trap controller bundle: pipeline-side requests and CSR/Fetch-side results.
// The pipeline drives the master side; trap_ctrl is the slave.
interface trap_ctrl_if #(
    parameter int N_IRQ      = 4,
    parameter int XLEN       = 32,
    parameter int NEST_DEPTH = 1
);
    localparam int DW = $clog2(NEST_DEPTH + 1);

    logic [N_IRQ-1:0] irq;
    logic [N_IRQ-1:0] irq_en;
    logic             mie_global;
    logic             ecall;
    logic             trap_ret;
    logic             stall;
    logic [XLEN-1:0]  epc_in;
    logic [XLEN-1:0]  mtvec;

    logic             trapping;
    logic             trigger_trap;
    logic             trigger_trap_ret;
    logic [XLEN-1:0]  trap_target;
    logic [XLEN-1:0]  ret_addr;
    logic [XLEN-1:0]  mepc;
    logic [XLEN-1:0]  mcause;
    logic [DW-1:0]    depth;
    logic [1:0]       err;

    modport master (
        output irq, irq_en, mie_global, ecall, trap_ret, stall, epc_in, mtvec,
        input  trapping, trigger_trap, trigger_trap_ret, trap_target, ret_addr,
               mepc, mcause, depth, err
    );

    modport slave (
        input  irq, irq_en, mie_global, ecall, trap_ret, stall, epc_in, mtvec,
        output trapping, trigger_trap, trigger_trap_ret, trap_target, ret_addr,
               mepc, mcause, depth, err
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: prioritised maskable interrupts plus ecall,
// bounded nesting stack of {epc, cause}, optional vectored dispatch.
module trap_ctrl #(
    parameter int N_IRQ      = 4,
    parameter int XLEN       = 32,
    parameter int NEST_DEPTH = 1,
    parameter int VECTORED   = 0
) (
    input logic        clk,
    input logic        Rst,
    trap_ctrl_if.slave bus
);
    localparam int            DW   = $clog2(NEST_DEPTH + 1);
    localparam logic [DW-1:0] FULL = DW'(NEST_DEPTH);

    logic [NEST_DEPTH-1:0][XLEN-1:0] stk_epc;
    logic [NEST_DEPTH-1:0][XLEN-1:0] stk_cause;
    logic [DW-1:0]   depth_q;
    logic [1:0]      err_q;
    logic            trig_q;
    logic            trig_ret_q;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] ret_q;

    logic [N_IRQ-1:0] act;
    logic             has_irq;
    logic [3:0]       irq_idx;
    logic [XLEN-1:0]  top_epc;
    logic [XLEN-1:0]  top_cause;
    logic             guard;
    logic             do_ret;
    logic             do_entry;
    logic             entry_ecall;
    logic             set_ovf;
    logic             set_udf;
    logic [XLEN-1:0]  base;
    logic [XLEN-1:0]  irq_code;
    logic [XLEN-1:0]  new_cause;
    logic [XLEN-1:0]  new_target;

    // Descending scan so the lowest-index active line wins.
    always_comb begin
        act     = bus.irq & bus.irq_en & {N_IRQ{bus.mie_global}};
        has_irq = 1'b0;
        irq_idx = '0;
        for (int unsigned i = N_IRQ; i > 0; i--) begin
            if (act[i-1]) begin
                has_irq = 1'b1;
                irq_idx = 4'(i - 1);
            end
        end
    end

    always_comb begin
        top_epc   = '0;
        top_cause = '0;
        for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) begin
                top_epc   = stk_epc[i];
                top_cause = stk_cause[i];
            end
        end
    end

    // A return owns its edge; ecall overflow is flagged even during the guard cycle.
    always_comb begin
        guard       = trig_q | trig_ret_q;
        do_ret      = bus.trap_ret && !bus.stall && (depth_q != '0);
        set_udf     = bus.trap_ret && !bus.stall && (depth_q == '0);
        set_ovf     = 1'b0;
        do_entry    = 1'b0;
        entry_ecall = 1'b0;
        if (!bus.stall && !bus.trap_ret) begin
            if (bus.ecall) begin
                if (depth_q == FULL) begin
                    set_ovf = 1'b1;
                end else if (!guard) begin
                    do_entry    = 1'b1;
                    entry_ecall = 1'b1;
                end
            end else if (has_irq && !guard) begin
                if (depth_q == '0) begin
                    do_entry = 1'b1;
                end else if (depth_q != FULL &&
                             (!top_cause[XLEN-1] || irq_idx < top_cause[3:0])) begin
                    do_entry = 1'b1;
                end
            end
        end

        base     = bus.mtvec & ~XLEN'(3);
        irq_code = XLEN'(16) + XLEN'(irq_idx);
        if (entry_ecall) begin
            new_cause  = XLEN'(11);
            new_target = base;
        end else begin
            new_cause          = irq_code;
            new_cause[XLEN-1]  = 1'b1;
            new_target         = (VECTORED != 0) ? base + (irq_code << 2) : base;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            stk_epc    <= '0;
            stk_cause  <= '0;
            depth_q    <= '0;
            err_q      <= '0;
            trig_q     <= 1'b0;
            trig_ret_q <= 1'b0;
            target_q   <= '0;
            ret_q      <= '0;
        end else begin
            trig_q     <= do_entry;
            trig_ret_q <= do_ret;
            err_q      <= err_q | {set_udf, set_ovf};
            if (do_entry) begin
                for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
                    if (depth_q == DW'(i)) begin
                        stk_epc[i]   <= bus.epc_in;
                        stk_cause[i] <= new_cause;
                    end
                end
                depth_q  <= depth_q + 1'b1;
                target_q <= new_target;
            end else if (do_ret) begin
                ret_q   <= top_epc;
                depth_q <= depth_q - 1'b1;
            end
        end
    end

    assign bus.trapping         = (depth_q != '0);
    assign bus.trigger_trap     = trig_q;
    assign bus.trigger_trap_ret = trig_ret_q;
    assign bus.trap_target      = target_q;
    assign bus.ret_addr         = ret_q;
    assign bus.mepc             = top_epc;
    assign bus.mcause           = top_cause;
    assign bus.depth            = depth_q;
    assign bus.err              = err_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a non-nesting, non-vectored instance (a) and a
// two-level vectored instance (b), with a scoreboard of expected redirects.
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic Rst;
    always #5 clk = ~clk;

    trap_ctrl_if #(.N_IRQ(4), .XLEN(32), .NEST_DEPTH(1)) bus_a ();
    trap_ctrl_if #(.N_IRQ(4), .XLEN(32), .NEST_DEPTH(2)) bus_b ();

    trap_ctrl #(.N_IRQ(4), .XLEN(32), .NEST_DEPTH(1), .VECTORED(0)) u_a (
        .clk(clk), .Rst(Rst), .bus(bus_a.slave));
    trap_ctrl #(.N_IRQ(4), .XLEN(32), .NEST_DEPTH(2), .VECTORED(1)) u_b (
        .clk(clk), .Rst(Rst), .bus(bus_b.slave));

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [1:0]  depth;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   passes = 0;
    bit   seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input bit on_b, input bit ret, output bit got);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (on_b) got = ret ? bus_b.trigger_trap_ret : bus_b.trigger_trap;
            else      got = ret ? bus_a.trigger_trap_ret : bus_a.trigger_trap;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        bus_a.irq = '0; bus_a.irq_en = '0; bus_a.mie_global = 1'b0;
        bus_a.ecall = 1'b0; bus_a.trap_ret = 1'b0; bus_a.stall = 1'b0;
        bus_a.epc_in = '0; bus_a.mtvec = '0;
        bus_b.irq = '0; bus_b.irq_en = '0; bus_b.mie_global = 1'b0;
        bus_b.ecall = 1'b0; bus_b.trap_ret = 1'b0; bus_b.stall = 1'b0;
        bus_b.epc_in = '0; bus_b.mtvec = '0;
        repeat (3) tick();
        checks++; if (bus_a.depth !== 1'b0 || bus_a.trigger_trap !== 1'b0 || bus_a.mcause !== 32'h0)
            $display("FAIL reset_a: depth=%0d trig=%b mcause=%h, want 0/0/0", bus_a.depth, bus_a.trigger_trap, bus_a.mcause);
        else passes++;
        checks++; if (bus_b.depth !== 2'd0 || bus_b.err !== 2'b00 || bus_b.trap_target !== 32'h0)
            $display("FAIL reset_b: depth=%0d err=%b target=%h, want 0", bus_b.depth, bus_b.err, bus_b.trap_target);
        else passes++;
        Rst = 1'b0;
        tick();

        // Reset while the entry redirect is still high
        bus_a.mtvec = 32'h100; bus_a.epc_in = 32'h40; bus_a.ecall = 1'b1;
        wait_pulse(1'b0, 1'b0, seen);
        bus_a.ecall = 1'b0;
        checks++; if (!seen) $display("FAIL reset_pre: trigger_trap never rose"); else passes++;
        Rst = 1'b1;
        #1;
        checks++; if (bus_a.trigger_trap !== 1'b0 || bus_a.depth !== 1'b0 || bus_a.trapping !== 1'b0 ||
                      bus_a.mepc !== 32'h0 || bus_a.mcause !== 32'h0 || bus_a.trap_target !== 32'h0 || bus_a.err !== 2'b00)
            $display("FAIL reset_mid: trig=%b depth=%0d mepc=%h mcause=%h target=%h err=%b, want all 0",
                     bus_a.trigger_trap, bus_a.depth, bus_a.mepc, bus_a.mcause, bus_a.trap_target, bus_a.err);
        else passes++;
        #1;
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_ecall();
        bus_a.mtvec = 32'h100; bus_a.epc_in = 32'h40;
        q.push_back('{addr: 32'h100, cause: 32'd11, epc: 32'h40, depth: 2'd1});
        bus_a.ecall = 1'b1;
        wait_pulse(1'b0, 1'b0, seen);
        bus_a.ecall = 1'b0;
        e = q.pop_front();
        checks++; if (!seen) $display("FAIL ecall_pulse: trigger_trap never rose"); else passes++;
        checks++; if (bus_a.trap_target !== e.addr) $display("FAIL ecall_target: got %h want %h", bus_a.trap_target, e.addr); else passes++;
        checks++; if (bus_a.mcause !== e.cause) $display("FAIL ecall_mcause: got %h want %h", bus_a.mcause, e.cause); else passes++;
        checks++; if (bus_a.mepc !== e.epc) $display("FAIL ecall_mepc: got %h want %h", bus_a.mepc, e.epc); else passes++;
        checks++; if ({1'b0, bus_a.depth} !== e.depth || bus_a.trapping !== 1'b1)
            $display("FAIL ecall_depth: got %0d trapping=%b want %0d/1", bus_a.depth, bus_a.trapping, e.depth); else passes++;
        tick();
        checks++; if (bus_a.trigger_trap !== 1'b0) $display("FAIL ecall_width: pulse still high"); else passes++;

        q.push_back('{addr: 32'h40, cause: 32'h0, epc: 32'h0, depth: 2'd0});
        bus_a.trap_ret = 1'b1;
        wait_pulse(1'b0, 1'b1, seen);
        bus_a.trap_ret = 1'b0;
        e = q.pop_front();
        checks++; if (!seen) $display("FAIL ret_pulse: trigger_trap_ret never rose"); else passes++;
        checks++; if (bus_a.ret_addr !== e.addr) $display("FAIL ret_addr: got %h want %h", bus_a.ret_addr, e.addr); else passes++;
        checks++; if ({1'b0, bus_a.depth} !== e.depth || bus_a.mcause !== e.cause)
            $display("FAIL ret_depth: depth=%0d mcause=%h want %0d/%h", bus_a.depth, bus_a.mcause, e.depth, e.cause); else passes++;
        tick();
        checks++; if (bus_a.trigger_trap_ret !== 1'b0) $display("FAIL ret_width: pulse still high"); else passes++;
    endtask

    task automatic test_stall();
        bus_a.epc_in = 32'h80; bus_a.ecall = 1'b1; bus_a.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_a.trigger_trap !== 1'b0 || bus_a.depth !== 1'b0)
                $display("FAIL stall_hold%0d: trig=%b depth=%0d want 0/0", i, bus_a.trigger_trap, bus_a.depth); else passes++;
        end
        bus_a.stall = 1'b0;
        tick();
        bus_a.ecall = 1'b0;
        checks++; if (bus_a.trigger_trap !== 1'b1 || bus_a.mepc !== 32'h80)
            $display("FAIL stall_release: trig=%b mepc=%h want 1/00000080", bus_a.trigger_trap, bus_a.mepc); else passes++;
        tick();
        bus_a.trap_ret = 1'b1; bus_a.stall = 1'b1;
        tick();
        checks++; if (bus_a.trigger_trap_ret !== 1'b0 || bus_a.depth !== 1'b1)
            $display("FAIL stall_ret_hold: ret=%b depth=%0d want 0/1", bus_a.trigger_trap_ret, bus_a.depth); else passes++;
        bus_a.stall = 1'b0;
        tick();
        bus_a.trap_ret = 1'b0;
        checks++; if (bus_a.trigger_trap_ret !== 1'b1 || bus_a.ret_addr !== 32'h80 || bus_a.depth !== 1'b0)
            $display("FAIL stall_ret: ret=%b addr=%h depth=%0d want 1/00000080/0", bus_a.trigger_trap_ret, bus_a.ret_addr, bus_a.depth); else passes++;
        tick();
    endtask

    task automatic test_overflow();
        bus_a.ecall = 1'b1;
        tick();
        bus_a.ecall = 1'b0;
        checks++; if (bus_a.trigger_trap !== 1'b1 || bus_a.depth !== 1'b1)
            $display("FAIL ovf_entry: trig=%b depth=%0d want 1/1", bus_a.trigger_trap, bus_a.depth); else passes++;
        tick();
        bus_a.ecall = 1'b1;
        tick();
        bus_a.ecall = 1'b0;
        checks++; if (bus_a.trigger_trap !== 1'b0 || bus_a.err !== 2'b01 || bus_a.depth !== 1'b1)
            $display("FAIL ovf: trig=%b err=%b depth=%0d want 0/01/1", bus_a.trigger_trap, bus_a.err, bus_a.depth); else passes++;
        bus_a.trap_ret = 1'b1;
        tick();
        bus_a.trap_ret = 1'b0;
        tick();
        bus_a.trap_ret = 1'b1;
        tick();
        bus_a.trap_ret = 1'b0;
        checks++; if (bus_a.trigger_trap_ret !== 1'b0 || bus_a.err !== 2'b11 || bus_a.depth !== 1'b0)
            $display("FAIL udf: ret=%b err=%b depth=%0d want 0/11/0", bus_a.trigger_trap_ret, bus_a.err, bus_a.depth); else passes++;
        tick();
    endtask

    task automatic test_vectored();
        bus_b.mtvec = 32'h201; bus_b.mie_global = 1'b1; bus_b.irq_en = 4'hF; bus_b.epc_in = 32'h500;
        q.push_back('{addr: 32'h244, cause: 32'h8000_0011, epc: 32'h500, depth: 2'd1});
        bus_b.irq = 4'b0110;
        wait_pulse(1'b1, 1'b0, seen);
        e = q.pop_front();
        checks++; if (!seen) $display("FAIL vec_pulse: trigger_trap never rose"); else passes++;
        checks++; if (bus_b.trap_target !== e.addr) $display("FAIL vec_target: got %h want %h", bus_b.trap_target, e.addr); else passes++;
        checks++; if (bus_b.mcause !== e.cause) $display("FAIL vec_mcause: got %h want %h", bus_b.mcause, e.cause); else passes++;
        checks++; if (bus_b.depth !== e.depth) $display("FAIL vec_depth: got %0d want %0d", bus_b.depth, e.depth); else passes++;
        tick(); tick();
        checks++; if (bus_b.trigger_trap !== 1'b0 || bus_b.depth !== 2'd1)
            $display("FAIL vec_no_self: trig=%b depth=%0d want 0/1", bus_b.trigger_trap, bus_b.depth); else passes++;
        bus_b.trap_ret = 1'b1;
        tick();
        bus_b.trap_ret = 1'b0;
        checks++; if (bus_b.trigger_trap_ret !== 1'b1 || bus_b.ret_addr !== 32'h500 || bus_b.depth !== 2'd0)
            $display("FAIL vec_ret: ret=%b addr=%h depth=%0d want 1/00000500/0", bus_b.trigger_trap_ret, bus_b.ret_addr, bus_b.depth); else passes++;
        tick();
        checks++; if (bus_b.trigger_trap !== 1'b0 || bus_b.depth !== 2'd0)
            $display("FAIL vec_guard: trig=%b depth=%0d want 0/0", bus_b.trigger_trap, bus_b.depth); else passes++;
        tick();
        checks++; if (bus_b.trigger_trap !== 1'b1 || bus_b.trap_target !== 32'h244 || bus_b.depth !== 2'd1)
            $display("FAIL vec_reentry: trig=%b target=%h depth=%0d want 1/00000244/1", bus_b.trigger_trap, bus_b.trap_target, bus_b.depth); else passes++;
        bus_b.irq = 4'b0000;
        tick();
        bus_b.trap_ret = 1'b1;
        tick();
        bus_b.trap_ret = 1'b0;
        tick();
    endtask

    task automatic test_nesting();
        bus_b.epc_in = 32'h300;
        q.push_back('{addr: 32'h248, cause: 32'h8000_0012, epc: 32'h300, depth: 2'd1});
        bus_b.irq = 4'b0100;
        wait_pulse(1'b1, 1'b0, seen);
        e = q.pop_front();
        checks++; if (!seen || bus_b.trap_target !== e.addr || bus_b.mcause !== e.cause || bus_b.depth !== e.depth)
            $display("FAIL nest_l1: seen=%b target=%h mcause=%h depth=%0d want 1/%h/%h/%0d",
                     seen, bus_b.trap_target, bus_b.mcause, bus_b.depth, e.addr, e.cause, e.depth); else passes++;
        bus_b.irq = 4'b1100;
        tick(); tick();
        checks++; if (bus_b.trigger_trap !== 1'b0 || bus_b.depth !== 2'd1)
            $display("FAIL nest_lower: trig=%b depth=%0d want 0/1", bus_b.trigger_trap, bus_b.depth); else passes++;
        bus_b.epc_in = 32'h304;
        q.push_back('{addr: 32'h240, cause: 32'h8000_0010, epc: 32'h304, depth: 2'd2});
        bus_b.irq = 4'b1101;
        wait_pulse(1'b1, 1'b0, seen);
        e = q.pop_front();
        checks++; if (!seen) $display("FAIL nest_pulse: trigger_trap never rose"); else passes++;
        checks++; if (bus_b.mcause !== e.cause) $display("FAIL nest_mcause: got %h want %h", bus_b.mcause, e.cause); else passes++;
        checks++; if (bus_b.depth !== e.depth || bus_b.mepc !== e.epc || bus_b.trap_target !== e.addr)
            $display("FAIL nest_l2: depth=%0d mepc=%h target=%h want %0d/%h/%h", bus_b.depth, bus_b.mepc, bus_b.trap_target, e.depth, e.epc, e.addr); else passes++;
        bus_b.irq = 4'b0000;
        tick();
        bus_b.trap_ret = 1'b1;
        wait_pulse(1'b1, 1'b1, seen);
        bus_b.trap_ret = 1'b0;
        checks++; if (!seen || bus_b.ret_addr !== 32'h304 || bus_b.depth !== 2'd1 ||
                      bus_b.mcause !== 32'h8000_0012 || bus_b.mepc !== 32'h300)
            $display("FAIL nest_ret: seen=%b addr=%h depth=%0d mcause=%h mepc=%h want 1/00000304/1/80000012/00000300",
                     seen, bus_b.ret_addr, bus_b.depth, bus_b.mcause, bus_b.mepc); else passes++;
        tick();
        bus_b.trap_ret = 1'b1;
        tick();
        bus_b.trap_ret = 1'b0;
        checks++; if (bus_b.ret_addr !== 32'h300 || bus_b.depth !== 2'd0 || bus_b.mcause !== 32'h0)
            $display("FAIL nest_ret2: addr=%h depth=%0d mcause=%h want 00000300/0/0", bus_b.ret_addr, bus_b.depth, bus_b.mcause); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        bus_b.epc_in = 32'h600;
        bus_b.irq = 4'b0001;
        wait_pulse(1'b1, 1'b0, seen);
        bus_b.irq = 4'b0000;
        checks++; if (!seen || bus_b.mcause !== 32'h8000_0010)
            $display("FAIL b2b_irq0: seen=%b mcause=%h want 1/80000010", seen, bus_b.mcause); else passes++;
        tick();
        bus_b.epc_in = 32'h604; bus_b.ecall = 1'b1;
        tick();
        bus_b.ecall = 1'b0;
        checks++; if (bus_b.trigger_trap !== 1'b1 || bus_b.depth !== 2'd2 || bus_b.mcause !== 32'd11 || bus_b.trap_target !== 32'h200)
            $display("FAIL b2b_ecall: trig=%b depth=%0d mcause=%h target=%h want 1/2/0000000b/00000200",
                     bus_b.trigger_trap, bus_b.depth, bus_b.mcause, bus_b.trap_target); else passes++;
        tick();
        bus_b.trap_ret = 1'b1; bus_b.ecall = 1'b1;
        tick();
        bus_b.trap_ret = 1'b0; bus_b.ecall = 1'b0;
        checks++; if (bus_b.trigger_trap_ret !== 1'b1 || bus_b.trigger_trap !== 1'b0 || bus_b.depth !== 2'd1 ||
                      bus_b.err !== 2'b00 || bus_b.ret_addr !== 32'h604)
            $display("FAIL b2b_conflict: ret=%b trig=%b depth=%0d err=%b addr=%h want 1/0/1/00/00000604",
                     bus_b.trigger_trap_ret, bus_b.trigger_trap, bus_b.depth, bus_b.err, bus_b.ret_addr); else passes++;
        tick();
        bus_b.trap_ret = 1'b1;
        tick();
        bus_b.trap_ret = 1'b0;
        tick();
        checks++; if (bus_b.depth !== 2'd0 || bus_b.err !== 2'b00 || bus_b.trigger_trap !== 1'b0)
            $display("FAIL b2b_final: depth=%0d err=%b trig=%b want 0/00/0", bus_b.depth, bus_b.err, bus_b.trigger_trap); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ecall();
        test_stall();
        test_overflow();
        test_vectored();
        test_nesting();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
